// File: rtl/data_ram_reader.sv
// Streams a contiguous range of a registered-address data RAM out over a valid/ready port.
// Optional feature macro: STREAM_CHECKSUM_EN adds a running checksum of the streamed words.
module data_ram_reader #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_dataOut,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef STREAM_CHECKSUM_EN
    output logic [WIDTH-1:0]      checksum,
`endif
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued;
    logic                  inflight;
    logic [WIDTH-1:0]      skid_data;
    logic                  skid_valid;
    logic                  pop;
    logic                  issue;
    logic [1:0]            occupancy;
    logic [ADDR_WIDTH:0]   len_clamped;

    // Output port: a word transfers on a rising clk edge where out_valid && out_ready;
    // out_valid never drops and out_data never changes until that transfer happens.
    assign pop = out_valid & out_ready;

    // Slots committed after this cycle's pop; a freed slot is reused in the same cycle.
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid} - {1'b0, pop} + {1'b0, inflight};
    assign issue     = (state == READ) && (occupancy < 2'd2);

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            len_q      <= '0;
            issued     <= '0;
            inflight   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= issue;

            if (issue) begin
                mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + ADDR_ONE;
                issued   <= issued + LEN_ONE;
            end

            // Head register is the output; the skid entry absorbs one word under backpressure.
            if (pop) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_valid  <= 1'b1;
                    skid_valid <= inflight;
                    if (inflight) skid_data <= mem_dataOut;
                end else begin
                    out_valid <= inflight;
                    if (inflight) out_data <= mem_dataOut;
                end
            end else if (!out_valid) begin
                out_valid <= inflight;
                if (inflight) out_data <= mem_dataOut;
            end else if (inflight) begin
                skid_valid <= 1'b1;
                skid_data  <= mem_dataOut;
            end

`ifdef STREAM_CHECKSUM_EN
            if (pop) checksum <= checksum + out_data;
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= baseAddr;
                        len_q    <= len_clamped;
                        issued   <= '0;
`ifdef STREAM_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (len_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && (issued + LEN_ONE == len_q)) state <= DRAIN;
                end
                DRAIN: begin
                    if (occupancy == 2'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_reader.sv
// Bench for data_ram_reader: RAM model, scoreboard queue of expected words, cycle-level sweep checks.
// Define STREAM_CHECKSUM_EN for both bench and RTL to cover the checksum port.
module tb_data_ram_reader;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    baseAddr;
    logic [AW:0]      len;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_dataOut = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [1:0]       state_dbg;
`ifdef STREAM_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    data_ram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .baseAddr    (baseAddr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_dataOut (mem_dataOut),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef STREAM_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .state_dbg   (state_dbg)
    );

    // ---- clock / RAM model ----
    always #5 clk = ~clk;

    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) mem_dataOut <= ram[mem_addr];

    // ---- scoreboard state ----
    int               vectors = 0;
    int               errors  = 0;
    int               hs_count = 0;
    int               ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low
    logic [WIDTH-1:0] exp_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---- sink ready driver ----
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = ($urandom_range(0, 99) < 60);
            default: out_ready = 1'b0;
        endcase
    end

    // ---- monitor: pops the expected queue on every handshake ----
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", {31'b0, out_valid}, 32'd1);
                check("stall_data_held", {20'b0, out_data}, {20'b0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    check("word", {20'b0, out_data}, {20'b0, exp_q.pop_front()});
                end
                hs_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---- driver: one sweep with cycle-level checks ----
    task automatic run_sweep(input int b, input int n, input bit timing, input int stall_at,
                             input bit poke);
        int               first_k = -1;
        int               done_k = -1;
        int               done_cnt = 0;
        bit               busy_seen = 0;
        bit               valid_seen = 0;
        int               budget = 4 * n + 64;
        logic [WIDTH-1:0] sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ram[(b + i) % DEPTH]);
            sum += ram[(b + i) % DEPTH];
        end
        @(posedge clk);
        #1;
        start    = 1'b1;
        baseAddr = AW'(b);
        len      = (AW+1)'(n);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (out_valid && first_k < 0) first_k = k;
            if (busy) busy_seen = 1;
            if (out_valid) valid_seen = 1;
            if (k == 0) check("busy_in_start_cycle", {31'b0, busy}, 32'd0);
            if (k == 1 && n > 0) check("busy_after_start", {31'b0, busy}, 32'd1);
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
`ifdef STREAM_CHECKSUM_EN
                    check("checksum_at_done", {20'b0, checksum}, {20'b0, sum});
`endif
                end
            end
            if (done_k >= 0 && k >= done_k + 3) break;
            @(posedge clk);
            #1;
            if (poke && k == 4) begin
                start    = 1'b1;
                baseAddr = AW'($urandom_range(0, DEPTH - 1));
                len      = 13'd3;
            end else begin
                start = 1'b0;
            end
            if (stall_at > 0 && k == stall_at) ready_mode = 3;
            if (stall_at > 0 && k == stall_at + 5) ready_mode = 1;
        end
        start = 1'b0;
        check("done_pulses", done_cnt, 32'd1);
        check("words_outstanding", exp_q.size(), 32'd0);
        if (n == 0) begin
            check("len0_done_cycle", done_k, 32'd1);
            check("len0_busy_seen", {31'b0, busy_seen}, 32'd0);
            check("len0_valid_seen", {31'b0, valid_seen}, 32'd0);
        end else if (timing) begin
            check("first_valid_cycle", first_k, 32'd3);
            check("done_cycle", done_k, n + 3);
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_out_data"}, {20'b0, out_data}, 32'd0);
        check({tag, "_mem_addr"}, {20'b0, mem_addr}, 32'd0);
`ifdef STREAM_CHECKSUM_EN
        check({tag, "_checksum"}, {20'b0, checksum}, 32'd0);
`endif
    endtask

    // ---- stimulus sequence ----
    initial begin
        int hs0;
        for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);
        rst = 1'b0;
        start = 1'b0;
        baseAddr = '0;
        len = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed sweeps
        ready_mode = 0;
        run_sweep(0, 8, 1, 0, 0);
        run_sweep(4094, 4, 1, 0, 0);
        ready_mode = 1;
        run_sweep(0, 16, 0, 6, 1);
        ready_mode = 0;
        run_sweep(5, 0, 1, 0, 0);

        // Reset after three of ten words
        for (int i = 0; i < 10; i++) exp_q.push_back(ram[i]);
        hs0 = hs_count;
        @(posedge clk);
        #1;
        start = 1'b1;
        baseAddr = '0;
        len = 13'd10;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (hs_count >= hs0 + 3) break;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("handshakes_before_reset", hs_count - hs0, 32'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midsweep_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_sweep(100, 2, 1, 0, 0);

        // Checksum wrap case
        for (int i = 0; i < 3; i++) ram[i] = 12'hFFF;
        run_sweep(0, 3, 1, 0, 0);

        // Randomized sweeps over random RAM contents
        for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'($urandom);
        for (int t = 0; t < 14; t++) begin
            int n;
            int b;
            ready_mode = $urandom_range(0, 2);
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(0, 40);
            if (t == 0) b = DEPTH - 3;
            run_sweep(b, n, ready_mode == 0, 0, (n >= 8) && ($urandom_range(0, 1) == 1));
        end

        // Full-depth sweep with wrap
        ready_mode = 0;
        run_sweep($urandom_range(1, DEPTH - 1), DEPTH, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
